// File: rtl/md_sequencer.sv
// Multiply/divide sequencer beside EX; owns HI/LO and services MFHI/MFLO/MTHI/MTLO.
// Latency: MUL_CYCLES or DIV_CYCLES busy cycles after accept; HI/LO update on the final busy edge.
// Backpressure: stall = busy & (start|mthi|mtlo|rd_hilo); the stalled request is taken once idle.
// Optional build macro MDU_CANCEL_EN adds the cancel port (abort in-flight op, HI/LO untouched).
module md_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        rd_hilo,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   count_q;
    logic [31:0]     opa_q;
    logic [31:0]     opb_q;
    logic [1:0]      op_q;
    logic            cancel_hit;
    logic            last_cycle;
    logic            finish;

    // Abort request only exists in the cancel-capable build.
`ifdef MDU_CANCEL_EN
    assign cancel_hit = cancel;
`else
    assign cancel_hit = 1'b0;
`endif

    assign last_cycle = (count_q == CW'(1));

    // ------------------------------------------------------------------
    // Result datapath, evaluated on the latched operands.
    // ------------------------------------------------------------------
    logic        is_signed;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // op bit 0 set means the unsigned flavour (MULTU/DIVU).
    assign is_signed = ~op_q[0];

    // Signed and unsigned products share one 64x64 multiplier via operand extension.
    always_comb begin
        if (is_signed) begin
            prod = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
        end else begin
            prod = {32'd0, opa_q} * {32'd0, opb_q};
        end
    end

    // Signed divide goes through magnitudes; the most-negative / -1 case falls out naturally.
    always_comb begin
        a_neg = is_signed & opa_q[31];
        b_neg = is_signed & opb_q[31];
        mag_a = a_neg ? (~opa_q + 32'd1) : opa_q;
        mag_b = b_neg ? (~opb_q + 32'd1) : opb_q;
        if (mag_b == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        div_q = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        div_r = a_neg ? (~ur + 32'd1) : ur;
    end

    // Select the HI/LO pair for the operation in flight; divide-by-zero never traps.
    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (op_q[1]) begin
            if (opb_q == 32'd0) begin
                res_hi = opa_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = div_r;
                res_lo = div_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept when idle, leave on the last count or on abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = op[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cancel_hit || last_cycle) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: busy from state, stall and the HI/LO write strobe derived from it.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        stall  = busy & (start | mthi | mtlo | rd_hilo);
        finish = busy & last_cycle & ~cancel_hit;
    end

    // ------------------------------------------------------------------
    // Datapath registers: operand latch, cycle counter, HI/LO.
    // ------------------------------------------------------------------

    // Latch operands at accept, count down while busy, write HI/LO at the end or on a move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (!busy) begin
            if (start) begin
                opa_q   <= a;
                opb_q   <= b;
                op_q    <= op;
                count_q <= op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else begin
                if (mthi) begin
                    hi <= a;
                end
                if (mtlo) begin
                    lo <= a;
                end
            end
        end else begin
            if (cancel_hit || last_cycle) begin
                count_q <= '0;
            end else begin
                count_q <= count_q - CW'(1);
            end
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

`ifndef SYNTHESIS
    // A move issued together with an accepted start is dropped; flag it in simulation.
    always @(posedge clk) begin
        if (rst_n && !busy && start && (mthi || mtlo)) begin
            $error("md_sequencer: start and mthi/mtlo together while idle, move ignored");
        end
    end
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized and directed bench for md_sequencer against a timestamp-based HI/LO model.
// Latency: model expects HI/LO update exactly N cycles after the accepting edge.
// Backpressure: stimulus holds its request while stall is high, like a frozen EX stage.
module tb_md_sequencer;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        rd_hilo = 1'b0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    md_sequencer #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .rd_hilo (rd_hilo),
`ifdef MDU_CANCEL_EN
        .cancel  (cancel),
`endif
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
            end
        end
    endtask

    // Architectural result of one md op, straight from the ISA arithmetic rules.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sp;
        int          sx;
        int          sy;
        int          sq;
        int          sr;
        logic [63:0] r;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin
                sp = longint'(sx) * longint'(sy);
                r  = sp;
            end
            2'd1: r = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr, sq};
                end
            end
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Model: an accepted op completes at a known cycle stamp; moves apply only when idle.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_busy;
    logic [63:0] m_res;
    int          m_done;
    int          cyc;
    logic        cancel_eff;

`ifdef MDU_CANCEL_EN
    assign cancel_eff = cancel;
`else
    assign cancel_eff = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_busy = 1'b0;
            m_res  = 64'd0;
            m_done = 0;
            cyc    = 0;
        end else begin
            if (m_busy) begin
                if (cancel_eff) begin
                    m_busy = 1'b0;
                end else if (cyc == m_done) begin
                    m_hi   = m_res[63:32];
                    m_lo   = m_res[31:0];
                    m_busy = 1'b0;
                end
            end else if (start) begin
                m_res  = ref_result(op, a, b);
                m_busy = 1'b1;
                m_done = cyc + (op[1] ? DIVN : MULN);
            end else begin
                if (mthi) m_hi = a;
                if (mtlo) m_lo = a;
            end
            cyc++;
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        chk("busy",  {63'd0, busy},  {63'd0, m_busy});
        chk("stall", {63'd0, stall}, {63'd0, m_busy & (start | mthi | mtlo | rd_hilo)});
        chk("hi",    {32'd0, hi},    {32'd0, m_hi});
        chk("lo",    {32'd0, lo},    {32'd0, m_lo});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        start   = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        rd_hilo = 1'b0;
        cancel  = 1'b0;
    endtask

    // Issue one op from idle, scramble operands afterwards, count busy cycles, check HI/LO.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int nexp, input logic [31:0] eh,
                         input logic [31:0] el);
        int k;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        k     = 0;
        while (busy && k < 200) begin
            k++;
            tick();
        end
        chk({nm, " busy cycles"}, 64'(k), 64'(nexp));
        chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
        chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        int s;
        logic hold;
        quiet();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset hi",   {32'd0, hi},   64'd0);
        chk("reset lo",   {32'd0, lo},   64'd0);

        do_op("MULT -3*7",    2'd0, 32'hFFFF_FFFD, 32'd7,         MULN, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("MULTU max^2",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULN, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("DIV -7/2",     2'd2, 32'hFFFF_FFF9, 32'd2,         DIVN, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("DIV by zero",  2'd2, 32'h0000_0055, 32'd0,         DIVN, 32'h0000_0055, 32'hFFFF_FFFF);
        do_op("DIV overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIVN, 32'h0000_0000, 32'h8000_0000);

        // MTHI while idle: HI written next edge, LO keeps the overflow quotient.
        a    = 32'h1234_5678;
        mthi = 1'b1;
        tick();
        mthi = 1'b0;
        chk("MTHI hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        chk("MTHI lo", {32'd0, lo}, {32'd0, 32'h8000_0000});

`ifdef MDU_CANCEL_EN
        // Cancel in the third busy cycle of a MULT: busy drops, HI/LO untouched.
        op    = 2'd0;
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel busy", {63'd0, busy}, 64'd0);
        chk("cancel hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        chk("cancel lo", {32'd0, lo}, {32'd0, 32'h8000_0000});
`endif

        // DIVU 100/7 with an MFHI right behind it: stall covers the whole busy window.
        op    = 2'd3;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start   = 1'b0;
        rd_hilo = 1'b1;
        k = 0;
        s = 0;
        while (busy && k < 200) begin
            k++;
            if (stall) s++;
            tick();
        end
        chk("DIVU stall cycles", 64'(s), 64'(DIVN));
        chk("DIVU stall released", {63'd0, stall}, 64'd0);
        chk("DIVU hi", {32'd0, hi}, 64'd2);
        chk("DIVU lo", {32'd0, lo}, 64'd14);
        rd_hilo = 1'b0;

        // Back-to-back: MULT 2*3 then MULTU 4*5 presented immediately and held under stall.
        op    = 2'd0;
        a     = 32'd2;
        b     = 32'd3;
        start = 1'b1;
        tick();
        op = 2'd1;
        a  = 32'd4;
        b  = 32'd5;
        k  = 0;
        s  = 0;
        while (busy && k < 200) begin
            k++;
            if (stall) s++;
            tick();
        end
        chk("b2b first stall", 64'(s), 64'(MULN));
        chk("b2b first lo", {32'd0, lo}, 64'd6);
        tick();
        start = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            k++;
            tick();
        end
        chk("b2b second busy", 64'(k), 64'(MULN));
        chk("b2b second lo", {32'd0, lo}, 64'd20);
        chk("b2b second hi", {32'd0, hi}, 64'd0);

        // Reset pulsed in the middle of a DIV: everything clears at once.
        op    = 2'd2;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid-DIV reset busy", {63'd0, busy}, 64'd0);
        chk("mid-DIV reset hi", {32'd0, hi}, 64'd0);
        chk("mid-DIV reset lo", {32'd0, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic; a stalled request is held exactly as a frozen pipeline would.
        for (int i = 0; i < 3000; i++) begin
            hold = stall;
            tick();
            cancel = 1'b0;
            if (!hold) begin
                quiet();
                case ($urandom_range(0, 9))
                    0, 1, 2: begin end
                    3, 4, 5: begin
                        start = 1'b1;
                        op    = 2'($urandom_range(0, 3));
                        a     = pick_operand();
                        b     = pick_operand();
                    end
                    6: begin mthi = 1'b1; a = $urandom; end
                    7: begin mtlo = 1'b1; a = $urandom; end
                    default: rd_hilo = 1'b1;
                endcase
            end
`ifdef MDU_CANCEL_EN
            cancel = ($urandom_range(0, 29) == 0);
`endif
        end
        quiet();
        repeat (DIVN + 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
